// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes one shared hex-to-7-segment decoder across
// DIGITS common-anode digits. Includes a blanking guard between digits,
// frame-synchronous double buffering of the display value, and optional
// leading-zero suppression.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_suppress,
  output logic [3:0]            dec_x,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic                  wrap_q;

  logic [4*DIGITS-1:0]   act_data;
  logic [4*DIGITS-1:0]   shd_data;
  logic [4*DIGITS-1:0]   act_data_nxt;
  logic [DIGITS-1:0]     act_dp;
  logic [DIGITS-1:0]     shd_dp;
  logic [DIGITS-1:0]     act_dp_nxt;
  logic                  pending;
  logic                  commit;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_sup;
  logic [DIGITS-1:0]     cur_an;
  logic                  all_zero;

  // Commit point: whenever idle, or on the edge that opens a new frame
  // (the same edge that raises frame_done).
  always_comb begin
    commit = (state == IDLE) || wrap_q;
  end

  // Value the active buffer takes at the next edge; a load coinciding with a
  // commit bypasses the shadow so the newest value wins.
  always_comb begin
    act_data_nxt = act_data;
    act_dp_nxt   = act_dp;
    if (commit) begin
      if (load) begin
        act_data_nxt = data_in;
        act_dp_nxt   = dp_in;
      end else if (pending) begin
        act_data_nxt = shd_data;
        act_dp_nxt   = shd_dp;
      end
    end
  end

  // Shadow/active double buffer and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data <= '0;
      act_dp   <= '0;
      shd_data <= '0;
      shd_dp   <= '0;
      pending  <= 1'b0;
    end else begin
      act_data <= act_data_nxt;
      act_dp   <= act_dp_nxt;
      if (load && !commit) begin
        shd_data <= data_in;
        shd_dp   <= dp_in;
        pending  <= 1'b1;
      end else if (commit) begin
        pending  <= 1'b0;
      end
    end
  end

  // Current digit's nibble, dp, anode pattern and suppression, scanning from
  // the most significant digit down so all_zero covers every index >= i.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_sup  = 1'b0;
    cur_an   = '1;
    all_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      all_zero = all_zero && (act_data_nxt[(DIGITS-1-k)*4 +: 4] == 4'd0);
      if (idx == IW'(DIGITS-1-k)) begin
        cur_nib               = act_data_nxt[(DIGITS-1-k)*4 +: 4];
        cur_dp                = act_dp_nxt[DIGITS-1-k];
        cur_sup               = lz_suppress && all_zero && (k != DIGITS-1);
        cur_an[DIGITS-1-k]    = 1'b0;
      end
    end
  end

  // Scan sequencer with registered outputs. Outputs are decoded from the
  // sequencer position before the edge, so they trail it by one cycle;
  // dropping enable overrides that and blanks on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      wrap_q     <= 1'b0;
      an_n       <= '1;
      dp_n       <= 1'b1;
      dec_x      <= '0;
      frame_done <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;

      if (!enable || state == IDLE) begin
        an_n <= '1;
        dp_n <= 1'b1;
      end else if (state == BLANK) begin
        an_n       <= '1;
        dec_x      <= cur_nib;
        dp_n       <= cur_sup | ~cur_dp;
        frame_done <= wrap_q;
      end else begin
        an_n <= cur_sup ? '1 : cur_an;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        BLANK: begin
          if (!enable) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
          end else if (cnt == CW'(BLANK_CYC - 1)) begin
            state <= SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (!enable) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
          end else if (cnt == CW'(SCAN_DIV - 1)) begin
            state <= BLANK;
            cnt   <= '0;
            if (idx == IW'(DIGITS - 1)) begin
              idx    <= '0;
              wrap_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: frame-position model plus directed vectors.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int unsigned ND  = 4;
  localparam int unsigned SD  = 4;
  localparam int unsigned BC  = 1;
  localparam int          PER = SD + BC;
  localparam int          FR  = ND * PER;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  dec_x;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .data_in(data_in), .dp_in(dp_in), .lz_suppress(lz_suppress),
    .dec_x(dec_x), .an_n(an_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_on: scanning; q: output-edge count since the first BLANK output of the
  // scan (frame position = q mod FR).
  bit          m_on = 1'b0;
  int          q = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic [3:0]  m_actdp = '0, m_shdp = '0;
  bit          m_pend = 1'b0;
  logic [3:0]  exp_dec = '0, exp_an = 4'hF;
  logic        exp_dp = 1'b1, exp_fd = 1'b0;

  function automatic bit suppressed(input logic [15:0] a, input int d, input bit lz);
    if (!lz || d == 0) return 1'b0;
    return (a >> (4 * d)) == 16'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit cm;
    int f, d, r;
    if (!rst_n) begin
      m_on = 0; q = 0; m_act = '0; m_sh = '0; m_actdp = '0; m_shdp = '0; m_pend = 0;
      exp_dec = '0; exp_an = 4'hF; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      if (!m_on) cm = 1'b1;
      else begin
        q++;
        cm = (q > 0) && (q % FR == 0);
      end
      if (load) begin
        if (cm) begin m_act = data_in; m_actdp = dp_in; m_pend = 0; end
        else begin m_sh = data_in; m_shdp = dp_in; m_pend = 1; end
      end else if (cm && m_pend) begin
        m_act = m_sh; m_actdp = m_shdp; m_pend = 0;
      end
      exp_fd = 1'b0;
      if (!m_on) begin
        exp_an = 4'hF; exp_dp = 1'b1;
        if (enable) begin m_on = 1; q = -1; end
      end else if (!enable) begin
        exp_an = 4'hF; exp_dp = 1'b1; m_on = 0;
      end else begin
        f = q % FR; d = f / PER; r = f % PER;
        exp_fd = (q > 0) && (f == 0);
        if (r < BC) begin
          exp_an  = 4'hF;
          exp_dec = m_act[4*d +: 4];
          exp_dp  = suppressed(m_act, d, lz_suppress) || !m_actdp[d];
        end else begin
          exp_an = suppressed(m_act, d, lz_suppress) ? 4'hF : ~(4'b0001 << d);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("dec_x", dec_x, exp_dec);
    chk("an_n", an_n, exp_an);
    chk("dp_n", {3'b0, dp_n}, {3'b0, exp_dp});
    chk("frame_done", {3'b0, frame_done}, {3'b0, exp_fd});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int c_bad, c_d0, c_d1, c_lit;
    step(2);
    chk("rst_an", an_n, 4'hF);
    chk("rst_dp", {3'b0, dp_n}, 4'h1);
    chk("rst_dec", dec_x, 4'h0);
    chk("rst_fd", {3'b0, frame_done}, 4'h0);
    rst_n = 1'b1;
    step(1);
    load = 1; data_in = 16'h4321; dp_in = 4'b0100;
    step(1);
    load = 0;
    enable = 1;                                    // t = 0
    step(2); chk("s_blank0_an", an_n, 4'hF); chk("s_blank0_dec", dec_x, 4'h1);
    step(1); chk("s_d0_an", an_n, 4'b1110); chk("s_d0_dp", {3'b0, dp_n}, 4'h1);
    step(4); chk("s_blank1_an", an_n, 4'hF); chk("s_blank1_dec", dec_x, 4'h2);
    step(1); chk("s_d1_an", an_n, 4'b1101);
    step(4); chk("s_blank2_dec", dec_x, 4'h3); chk("s_blank2_dp", {3'b0, dp_n}, 4'h0);
    step(1); chk("s_d2_an", an_n, 4'b1011); chk("s_d2_dp", {3'b0, dp_n}, 4'h0);
    step(8); chk("s_fd_before", {3'b0, frame_done}, 4'h0);   // t = 21
    step(1); chk("s_fd", {3'b0, frame_done}, 4'h1); chk("s_f2_dec", dec_x, 4'h1); // t = 22
    // tear-free update while digit 1 of frame 2 is shown
    step(6); load = 1; data_in = 16'hABCD; dp_in = 4'b0000;  // t = 28
    step(1); load = 0;                                        // t = 29
    step(3); chk("tf_d2_dec", dec_x, 4'h3);                   // t = 32
    step(5); chk("tf_d3_dec", dec_x, 4'h4);                   // t = 37
    step(5); chk("tf_fd", {3'b0, frame_done}, 4'h1); chk("tf_new_dec", dec_x, 4'hD); // t = 42
    // load sampled on the edge that raises frame_done
    step(19); load = 1; data_in = 16'h00F0;                   // t = 61
    step(1); load = 0;                                        // t = 62
    chk("col_fd", {3'b0, frame_done}, 4'h1); chk("col_d0", dec_x, 4'h0);
    step(5); chk("col_d1", dec_x, 4'hF);                      // t = 67
    // load one cycle earlier goes through pending
    step(13); load = 1; data_in = 16'h0070;                   // t = 80
    step(1); load = 0; chk("pend_fd0", {3'b0, frame_done}, 4'h0); // t = 81
    step(1); chk("pend_fd", {3'b0, frame_done}, 4'h1); chk("pend_d0", dec_x, 4'h0); // t = 82
    step(5); chk("pend_d1", dec_x, 4'h7);                     // t = 87
    // leading-zero suppression, active = 0050
    lz_suppress = 1; load = 1; data_in = 16'h0050;
    step(1); load = 0;                                        // t = 88
    step(14);                                                 // t = 102
    c_bad = 0; c_d0 = 0; c_d1 = 0;
    for (int i = 0; i < FR; i++) begin
      step(1);
      if (an_n[3] == 1'b0 || an_n[2] == 1'b0) c_bad++;
      if (an_n == 4'b1110) c_d0++;
      if (an_n == 4'b1101) c_d1++;
    end                                                       // t = 122
    chk("lz_upper_lit", c_bad[3:0], 4'd0);
    chk("lz_d0_cycles", c_d0[3:0], 4'd4);
    chk("lz_d1_cycles", c_d1[3:0], 4'd4);
    // active = 0000: only digit 0 lit
    load = 1; data_in = 16'h0000;
    step(1); load = 0;                                        // t = 123
    step(19);                                                 // t = 142
    c_lit = 0; c_d0 = 0;
    for (int i = 0; i < FR; i++) begin
      step(1);
      if (an_n != 4'hF) c_lit++;
      if (an_n == 4'b1110) c_d0++;
    end                                                       // t = 162
    chk("lz0_lit_cycles", c_lit[3:0], 4'd4);
    chk("lz0_d0_cycles", c_d0[3:0], 4'd4);
    // disable during SHOW of digit 2
    lz_suppress = 0; load = 1; data_in = 16'h4321; dp_in = 4'b0100;
    step(1); load = 0;                                        // t = 163
    step(11); chk("dis_d2_an", an_n, 4'b1011);                // t = 174
    enable = 0;
    step(1); chk("dis_an", an_n, 4'hF); chk("dis_fd", {3'b0, frame_done}, 4'h0);
    step(3); enable = 1;
    step(2); chk("re_blank_an", an_n, 4'hF); chk("re_blank_dec", dec_x, 4'h1);
    step(1); chk("re_d0_an", an_n, 4'b1110);
    step(1);
    // asynchronous reset in the middle of SHOW
    #2 rst_n = 0;
    #1;
    chk("arst_an", an_n, 4'hF);
    chk("arst_dp", {3'b0, dp_n}, 4'h1);
    chk("arst_dec", dec_x, 4'h0);
    chk("arst_fd", {3'b0, frame_done}, 4'h0);
    @(negedge clk); rst_n = 1;
    step(2); chk("rel_e2_an", an_n, 4'hF);
    step(1); chk("rel_e3_an", an_n, 4'b1110);
    step(3); chk("rel_e6_an", an_n, 4'b1110);
    step(1); chk("rel_e7_an", an_n, 4'hF);
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
